pet_stat_engine: RTL
====================

// Module: pet_stat_engine
// PURPOSE
//  Parametrised successor to the single-pet game-state logic. Tracks N_STATS saturating pet
//  statistics (hunger, boredom, fatigue, ...) that decay once per DECAY_FRAMES video frames.
//  Keyboard actions restore individual stats. A mood FSM drives sprite selection and
//  eaten/hurt flags for the colour mapper. All logic runs on Clk. frame_vs is the VGA vsync
//  from the vga_controller; this block synchronises it internally.
// PARAMETERS
//  N_STATS      3      number of stat channels (1..8)
//  STAT_W       8      width of each stat counter
//  STAT_MAX     100    saturation ceiling; a stat at STAT_MAX is "critical"
//  DECAY_FRAMES 60     frames between +1 decay steps (>=1)
//  BOOST        20     amount subtracted from a stat by its action key
//  KEY_BASE     8'h1E  keycode for channel 0; channel i uses KEY_BASE+i
//  ANIM_FRAMES  30     frames spent in EATING after an action
//  DEATH_FRAMES 300    consecutive frames in HURT before DEAD
// PORTS
//  Clk        in   1                 system clock
//  Reset      in   1                 synchronous, active-high reset
//  frame_vs   in   1                 VGA vsync, asynchronous to nothing but treated as raw; rising edge = new frame
//  keycode    in   8                 current USB keycode, 8'h00 = no key
//  stats      out  N_STATS*STAT_W    stat i at [i*STAT_W +: STAT_W]
//  sprite_sel out  2                 0 IDLE, 1 EATING, 2 HURT, 3 DEAD
//  eaten      out  1                 one-Clk pulse on each accepted action
//  hurt       out  1                 high while any stat == STAT_MAX
//  frame_tick out  1                 one-Clk pulse per detected frame
// BEHAVIOUR
//  Reset (sync, Clk edge with Reset=1): all stats=0, FSM=IDLE, all counters=0.
//   sprite_sel=0, eaten=0, hurt=0, frame_tick=0. Reset overrides every event in the same cycle.
//  Frame detect: 2-flop sync of frame_vs plus 1 edge register. frame_tick is asserted
//   exactly 3 Clk edges after the vs rise is sampled. At most one frame_tick per vs rise.
//  Decay: a frame counter counts frame_ticks 0..DECAY_FRAMES-1.
//   On the tick that wraps it to 0, every stat does s = min(s+1, STAT_MAX).
//  Action: key edge = keycode != previous keycode AND keycode == KEY_BASE+i with i<N_STATS.
//   Held keys do not repeat. Changing directly from one action key to another counts as a new edge.
//   On the next Clk: stat i = (s>BOOST) ? s-BOOST : 0, and eaten pulses for 1 Clk.
//   Actions are ignored in DEAD. Actions are accepted in HURT and restart EATING.
//  Simultaneous decay+action on the same cycle: decay is applied first, then the action.
//   Result = sat0(min(s+1,STAT_MAX) - BOOST). eaten still pulses.
//  Arithmetic: internal STAT_W+1 bits. No wrap-around ever: saturate at 0 and STAT_MAX.
//  hurt is combinational from registered stats: OR over i of (stat i == STAT_MAX).
//  FSM (registered; sprite_sel = state encoding):
//   IDLE   -> EATING on action; -> HURT if hurt and no action.
//   EATING -> counts ANIM_FRAMES frame_ticks, then goes to HURT if hurt else IDLE. A new action reloads the count.
//   HURT   -> EATING on action; -> IDLE when hurt falls.
//            Counts consecutive frame_ticks in HURT; at DEATH_FRAMES -> DEAD.
//   DEAD   -> terminal until Reset. Stats freeze (no decay, no action).
//   The death counter clears on every exit from HURT.
//  Reset mid-animation or mid-death-count: all progress discarded, and the next frame starts at counter 0.
// TESTING
//  1 Reset, then 60 frames (DECAY_FRAMES=60) -> all stats=1, hurt=0, sprite_sel=0.
//  2 Stat0=5, keycode 00->1E held 10 frames -> stat0=0 (saturate).
//    eaten pulses exactly once; sprite_sel=1 for 30 frames, then 0.
//  3 Stat1 at 100, decay tick -> stat1 stays 100, hurt=1, sprite_sel=2.
//    Key 1F -> stat1=80, sprite_sel=1.
//  4 Decay wrap and key 1E on the same Clk with stat0=50 -> stat0=31, eaten=1.
//  5 Hold stat2=100 for 300 frames -> sprite_sel=3. Keys/decay then leave stats frozen.
//    Reset -> all 0, IDLE.
//  6 Assert Reset in the middle of EATING at frame 15 -> outputs 0 the next Clk.
//    The next action runs the full 30-frame animation.

Source files
------------

// File: rtl/pet_stat_engine.sv
// Pet statistics engine: N_STATS saturating stats that decay once per DECAY_FRAMES
// video frames, keyboard actions that restore them, and a mood FSM for the sprite mapper.

module pet_stat_lane #(
  parameter int STAT_W   = 8,
  parameter int STAT_MAX = 100,
  parameter int BOOST    = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              decay_i,
  input  logic              act_i,
  output logic [STAT_W-1:0] stat_o
);
  localparam logic [STAT_W:0] MAX_W   = (STAT_W+1)'(STAT_MAX);
  localparam logic [STAT_W:0] BOOST_W = (STAT_W+1)'(BOOST);

  logic [STAT_W-1:0] stat_q, stat_d;
  logic [STAT_W:0]   inc, decayed;

  // Decay lands first so a coincident action subtracts from the decayed value.
  always_comb begin
    inc     = {1'b0, stat_q} + 1'b1;
    decayed = {1'b0, stat_q};
    if (decay_i) decayed = (inc > MAX_W) ? MAX_W : inc;
    stat_d = STAT_W'(decayed);
    if (act_i) stat_d = (decayed > BOOST_W) ? STAT_W'(decayed - BOOST_W) : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_o = stat_q;
endmodule

module pet_stat_engine #(
  parameter int         N_STATS      = 3,
  parameter int         STAT_W       = 8,
  parameter int         STAT_MAX     = 100,
  parameter int         DECAY_FRAMES = 60,
  parameter int         BOOST        = 20,
  parameter logic [7:0] KEY_BASE     = 8'h1E,
  parameter int         ANIM_FRAMES  = 30,
  parameter int         DEATH_FRAMES = 300
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_vs,
  input  logic [7:0]                keycode,
  output logic [N_STATS*STAT_W-1:0] stats,
  output logic [1:0]                sprite_sel,
  output logic                      eaten,
  output logic                      hurt,
  output logic                      frame_tick
);
  localparam int FC_W    = $clog2(DECAY_FRAMES + 1);
  localparam int ANIM_W  = $clog2(ANIM_FRAMES + 1);
  localparam int DEATH_W = $clog2(DEATH_FRAMES + 1);

  typedef enum logic [1:0] {S_IDLE, S_EATING, S_HURT, S_DEAD} state_e;

  state_e               state_q, state_d;
  logic                 vs_s1_q, vs_s2_q, vs_s3_q, tick_q;
  logic [FC_W-1:0]      frm_q, frm_d;
  logic [ANIM_W-1:0]    anim_q, anim_d;
  logic [DEATH_W-1:0]   death_q, death_d;
  logic [7:0]           key_prev_q;
  logic                 eaten_q;
  logic                 key_new, decay, act_any, hurt_w;
  logic [N_STATS-1:0]   act_vec;
  logic [N_STATS-1:0][STAT_W-1:0] stat_q;

  assign key_new = (keycode != key_prev_q);
  assign decay   = tick_q && (frm_q == FC_W'(DECAY_FRAMES - 1)) && (state_q != S_DEAD);
  assign act_any = |act_vec;

  for (genvar i = 0; i < N_STATS; i++) begin : g_lane
    assign act_vec[i] = key_new && (keycode == 8'(KEY_BASE + i)) && (state_q != S_DEAD);
    pet_stat_lane #(.STAT_W(STAT_W), .STAT_MAX(STAT_MAX), .BOOST(BOOST)) u_lane (
      .Clk(Clk), .Reset(Reset), .decay_i(decay), .act_i(act_vec[i]), .stat_o(stat_q[i])
    );
  end

  always_comb begin
    hurt_w = 1'b0;
    for (int i = 0; i < N_STATS; i++)
      if (stat_q[i] == STAT_W'(STAT_MAX)) hurt_w = 1'b1;
  end

  always_comb begin
    frm_d = frm_q;
    if (tick_q) frm_d = (frm_q == FC_W'(DECAY_FRAMES - 1)) ? '0 : frm_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    anim_d  = anim_q;
    death_d = death_q;
    case (state_q)
      S_IDLE: begin
        if (act_any) begin
          state_d = S_EATING;
          anim_d  = '0;
        end else if (hurt_w) state_d = S_HURT;
      end
      S_EATING: begin
        if (act_any) anim_d = '0;
        else if (tick_q) begin
          if (anim_q == ANIM_W'(ANIM_FRAMES - 1)) begin
            state_d = hurt_w ? S_HURT : S_IDLE;
            anim_d  = '0;
          end else anim_d = anim_q + 1'b1;
        end
      end
      S_HURT: begin
        // Death progress only survives while we stay in HURT.
        if (act_any) begin
          state_d = S_EATING;
          anim_d  = '0;
          death_d = '0;
        end else if (!hurt_w) begin
          state_d = S_IDLE;
          death_d = '0;
        end else if (tick_q) begin
          if (death_q == DEATH_W'(DEATH_FRAMES - 1)) begin
            state_d = S_DEAD;
            death_d = '0;
          end else death_d = death_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_s1_q    <= 1'b0;
      vs_s2_q    <= 1'b0;
      vs_s3_q    <= 1'b0;
      tick_q     <= 1'b0;
      frm_q      <= '0;
      anim_q     <= '0;
      death_q    <= '0;
      key_prev_q <= '0;
      eaten_q    <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      vs_s1_q    <= frame_vs;
      vs_s2_q    <= vs_s1_q;
      vs_s3_q    <= vs_s2_q;
      tick_q     <= vs_s2_q && !vs_s3_q;
      frm_q      <= frm_d;
      anim_q     <= anim_d;
      death_q    <= death_d;
      key_prev_q <= keycode;
      eaten_q    <= act_any;
      state_q    <= state_d;
    end
  end

  assign stats      = stat_q;
  assign sprite_sel = state_q;
  assign eaten      = eaten_q;
  assign hurt       = hurt_w;
  assign frame_tick = tick_q;
endmodule
